// File: rtl/twiddle_gen.sv
// twiddle_gen: full-circle FFT twiddle generator with radix-2 DIF stage sequencer
module twiddle_gen #(
    parameter int BW_FFTP = 4,
    parameter int BW_DATA = 18
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               ClockEn,
    input  logic               Inverse,
    input  logic               i_Valid,
    input  logic [BW_FFTP-1:0] i_Theta,
    input  logic               Start,
    input  logic [4:0]         Stage,
    output logic               Busy,
    output logic               o_Valid,
    output logic               o_Last,
    output logic [BW_DATA-1:0] Cosine,
    output logic [BW_DATA-1:0] nSine
);
    localparam int LP_N  = 1 << BW_FFTP;
    localparam int LP_M  = LP_N / 4;
    localparam int LP_AW = BW_FFTP - 1;
    localparam int LP_JW = BW_FFTP - 1;

    // Quarter-wave sine entries are computed at elaboration, so no image file is needed
    function automatic int f_sine(input int r);
        real x, t, s;
        x = 2.0 * 3.14159265358979323846 * $itor(r) / $itor(LP_N);
        t = x;
        s = x;
        for (int n = 1; n < 16; n++) begin
            t = -t * x * x / $itor((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return $rtoi(s * (2.0 ** (BW_DATA - 2)) + 0.5);
    endfunction

    logic signed [BW_DATA-1:0] w_rom [0:LP_M];
    for (genvar g = 0; g <= LP_M; g++) begin : g_rom
        localparam int LP_VAL = f_sine(g);
        assign w_rom[g] = BW_DATA'(LP_VAL);
    end

    typedef enum logic {IDLE, RUN} t_state;
    t_state           r_state;
    logic [LP_JW-1:0] r_j;
    logic [4:0]       r_stage;
    logic             r_inv;

    logic [4:0]         w_stage;
    logic [BW_FFTP-1:0] w_seq_k;
    logic               w_req_v;
    logic               w_req_last;
    logic               w_req_inv;
    logic [BW_FFTP-1:0] w_req_k;
    logic [BW_FFTP-3:0] w_r;

    assign Busy       = (r_state == RUN);
    assign w_stage    = (Stage >= 5'(BW_FFTP - 1)) ? 5'(BW_FFTP - 1) : Stage;
    assign w_seq_k    = BW_FFTP'((int'(r_j) & ((LP_N >> (int'(r_stage) + 1)) - 1)) << r_stage);
    assign w_req_v    = Busy | (i_Valid & ~Start);
    assign w_req_last = Busy & (&r_j);
    assign w_req_inv  = Busy ? r_inv : Inverse;
    assign w_req_k    = Busy ? w_seq_k : i_Theta;
    assign w_r        = w_req_k[BW_FFTP-3:0];

    // Stage sequencer: Start latches stage/sign, then one request per enabled cycle
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
            r_j     <= '0;
            r_stage <= '0;
            r_inv   <= 1'b0;
        end else if (ClockEn) begin
            if (r_state == IDLE) begin
                if (Start) begin
                    r_state <= RUN;
                    r_j     <= '0;
                    r_stage <= w_stage;
                    r_inv   <= Inverse;
                end
            end else begin
                r_j <= r_j + 1'b1;
                if (&r_j) r_state <= IDLE;
            end
        end
    end

    logic             r1_v, r1_last, r1_inv;
    logic [1:0]       r1_q;
    logic [LP_AW-1:0] r1_ar, r1_amr;

    // P1: register quadrant and the two mirrored table addresses
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r1_v    <= 1'b0;
            r1_last <= 1'b0;
            r1_inv  <= 1'b0;
            r1_q    <= '0;
            r1_ar   <= '0;
            r1_amr  <= '0;
        end else if (ClockEn) begin
            r1_v    <= w_req_v;
            r1_last <= w_req_last;
            r1_inv  <= w_req_inv;
            r1_q    <= w_req_k[BW_FFTP-1 -: 2];
            r1_ar   <= {1'b0, w_r};
            r1_amr  <= LP_AW'(LP_M - int'(w_r));
        end
    end

    logic                      r2_v, r2_last, r2_inv;
    logic [1:0]                r2_q;
    logic signed [BW_DATA-1:0] r2_sa, r2_sb;

    // P2: registered dual read of the quarter-wave table
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r2_v    <= 1'b0;
            r2_last <= 1'b0;
            r2_inv  <= 1'b0;
            r2_q    <= '0;
            r2_sa   <= '0;
            r2_sb   <= '0;
        end else if (ClockEn) begin
            r2_v    <= r1_v;
            r2_last <= r1_last;
            r2_inv  <= r1_inv;
            r2_q    <= r1_q;
            r2_sa   <= w_rom[r1_ar];
            r2_sb   <= w_rom[r1_amr];
        end
    end

    logic signed [BW_DATA-1:0] w_cos, w_sin, w_nsin;

    assign w_cos  = (r2_q == 2'd0) ? r2_sb : (r2_q == 2'd1) ? -r2_sa : (r2_q == 2'd2) ? -r2_sb : r2_sa;
    assign w_sin  = (r2_q == 2'd0) ? r2_sa : (r2_q == 2'd1) ? r2_sb : (r2_q == 2'd2) ? -r2_sa : -r2_sb;
    assign w_nsin = r2_inv ? w_sin : -w_sin;

    // P3: quadrant sign selection into the output registers, held while idle
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            o_Valid <= 1'b0;
            o_Last  <= 1'b0;
            Cosine  <= '0;
            nSine   <= '0;
        end else if (ClockEn) begin
            o_Valid <= r2_v;
            o_Last  <= r2_last;
            if (r2_v) begin
                Cosine <= w_cos;
                nSine  <= w_nsin;
            end
        end
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: randomized and directed checks of twiddle_gen against a trig reference model
module tb_twiddle_gen;
    localparam int  P  = 4;
    localparam int  BW = 18;
    localparam int  N  = 16;
    localparam real A  = 65536.0;

    logic                 Clock = 1'b0;
    logic                 nReset, ClockEn, Inverse, i_Valid, Start;
    logic [P-1:0]         i_Theta;
    logic [4:0]           Stage;
    logic                 Busy, o_Valid, o_Last;
    logic signed [BW-1:0] Cosine, nSine;

    twiddle_gen #(.BW_FFTP(P), .BW_DATA(BW)) dut (
        .Clock(Clock), .nReset(nReset), .ClockEn(ClockEn), .Inverse(Inverse),
        .i_Valid(i_Valid), .i_Theta(i_Theta), .Start(Start), .Stage(Stage),
        .Busy(Busy), .o_Valid(o_Valid), .o_Last(o_Last), .Cosine(Cosine), .nSine(nSine)
    );

    always #5 Clock = ~Clock;

    typedef struct {int c; int s; int last; int due;} exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int busy_cnt = 0;
    int words    = 0;
    int last_c   = 0;
    int last_s   = 0;
    logic en_edge = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic void push_exp(input int c, input int s, input bit last, input int due);
        exp_t e;
        e.c = c; e.s = s; e.last = int'(last); e.due = due;
        exp_q.push_back(e);
    endfunction

    function automatic void push_model(input int k, input bit inv, input bit last, input int due);
        real a;
        int  s;
        a = 2.0 * 3.14159265358979 * k / N;
        s = rnd(A * $sin(a));
        push_exp(rnd(A * $cos(a)), inv ? s : -s, last, due);
    endfunction

    always @(posedge Clock) begin
        en_edge <= ClockEn && nReset;
        if (ClockEn && nReset) en_cnt <= en_cnt + 1;
    end

    always @(negedge Clock) begin
        exp_t e;
        if (nReset) begin
            if (en_edge) begin
                if (Busy) busy_cnt++;
                if (o_Valid) begin
                    if (exp_q.size() == 0) check("extra_word", int'(o_Valid), 0);
                    else begin
                        e = exp_q.pop_front();
                        check("cosine", Cosine, e.c);
                        check("nsine", nSine, e.s);
                        check("last", int'(o_Last), e.last);
                        check("arrival_cycle", en_cnt, e.due);
                        words++;
                    end
                end else if (exp_q.size() != 0 && exp_q[0].due <= en_cnt) begin
                    check("missing_word", int'(o_Valid), 1);
                    void'(exp_q.pop_front());
                end
            end
            if (!o_Valid) begin
                check("hold_cos", Cosine, last_c);
                check("hold_nsin", nSine, last_s);
            end
            last_c = Cosine;
            last_s = nSine;
        end else begin
            last_c = 0;
            last_s = 0;
        end
    end

    task automatic tick;
        @(posedge Clock);
        #2;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick;
            t++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) tick;
    endtask

    task automatic direct(input int k, input bit inv);
        i_Valid = 1'b1; i_Theta = P'(k); Inverse = inv;
        push_model(k, inv, 1'b0, en_cnt + 3);
        tick;
        i_Valid = 1'b0;
    endtask

    task automatic direct_c(input int k, input bit inv, input int c, input int s);
        i_Valid = 1'b1; i_Theta = P'(k); Inverse = inv;
        push_exp(c, s, 1'b0, en_cnt + 3);
        tick;
        i_Valid = 1'b0;
    endtask

    task automatic start_seq(input int stage, input bit inv, input bit contend);
        int s;
        s = (stage >= P - 1) ? P - 1 : stage;
        Start = 1'b1; Stage = 5'(stage); Inverse = inv;
        i_Valid = contend; i_Theta = P'($urandom);
        for (int j = 0; j < N / 2; j++)
            push_model((j % (N >> (s + 1))) << s, inv, j == N / 2 - 1, en_cnt + 4 + j);
        tick;
        Start = 1'b0; i_Valid = 1'b0; Inverse = 1'($urandom);
    endtask

    int dk[5] = '{0, 2, 4, 8, 12};
    int dc[5] = '{65536, 46341, 0, -65536, 0};
    int ds[5] = '{0, -46341, -65536, 0, 65536};

    initial begin
        int w0, t;
        nReset = 1'b0; ClockEn = 1'b1; Inverse = 1'b0; i_Valid = 1'b0;
        Start = 1'b0; i_Theta = '0; Stage = '0;
        repeat (3) tick;
        check("rst_busy", int'(Busy), 0);
        check("rst_valid", int'(o_Valid), 0);
        check("rst_last", int'(o_Last), 0);
        check("rst_cos", Cosine, 0);
        check("rst_nsin", nSine, 0);
        nReset = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) direct_c(dk[i], 1'b0, dc[i], ds[i]);
        drain;
        for (int i = 0; i < 5; i++) direct_c(dk[i], 1'b1, dc[i], -ds[i]);
        drain;
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < N; k++) direct(k, 1'(v));
        drain;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) direct(int'($urandom_range(0, N - 1)), 1'($urandom));
            else tick;
        end
        drain;
        busy_cnt = 0;
        start_seq(1, 1'b0, 1'b1);
        repeat (4) begin
            Start = 1'b1; i_Valid = 1'b1; i_Theta = P'($urandom);
            tick;
        end
        Start = 1'b0; i_Valid = 1'b0;
        drain;
        check("busy_cycles", busy_cnt, 8);
        start_seq(0, 1'b1, 1'b0);
        drain;
        start_seq(7, 1'b0, 1'b0);
        drain;
        start_seq(1, 1'b1, 1'b0);
        repeat (8) tick;
        start_seq(2, 1'b0, 1'b0);
        drain;
        for (int r = 0; r < 2; r++) begin
            start_seq(r * 2, 1'(r), 1'b0);
            for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
                ClockEn = 1'($urandom_range(0, 1));
                tick;
            end
            ClockEn = 1'b1;
            drain;
        end
        w0 = words;
        start_seq(1, 1'b0, 1'b0);
        t = 0;
        while (words < w0 + 3 && t < 100) begin
            tick;
            t++;
        end
        check("reset_wait", words - w0, 3);
        #1 nReset = 1'b0;
        #1;
        check("abort_busy", int'(Busy), 0);
        check("abort_valid", int'(o_Valid), 0);
        check("abort_last", int'(o_Last), 0);
        check("abort_cos", Cosine, 0);
        check("abort_nsin", nSine, 0);
        exp_q.delete();
        repeat (2) tick;
        nReset = 1'b1;
        tick;
        direct_c(4, 1'b0, 0, -65536);
        drain;
        repeat (10) tick;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
